// File: rtl/mmu_sequencer.sv
// Host-facing tile loader and pass sequencer for the 2x2 MMU feeder.
// Collects weight/input bytes, runs one en pass, then clears the array.
module mmu_sequencer #(
  parameter int LAST_CYCLE = 5,
  parameter int CLEAR_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       reuse_weights,
  output logic       load_ready,
  output logic       en,
  output logic [2:0] mmu_cycle,
  output logic [7:0] weight0,
  output logic [7:0] weight1,
  output logic [7:0] weight2,
  output logic [7:0] weight3,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic [7:0] input2,
  output logic [7:0] input3,
  output logic       busy,
  output logic [7:0] tile_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] LAST    = 3'(LAST_CYCLE);
  localparam logic [3:0] GAP_END = 4'(CLEAR_GAP - 1);

  state_t     state;
  logic [2:0] byte_idx;
  logic       weights_valid;
  logic [3:0] gap;
  logic       accept;
  logic       skip_w;

  assign accept = load_valid && load_ready;
  assign skip_w = (byte_idx == 3'd0) && reuse_weights && weights_valid;
  assign busy   = (state == RUN) || (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      byte_idx      <= 3'd0;
      weights_valid <= 1'b0;
      gap           <= 4'd0;
      load_ready    <= 1'b0;
      en            <= 1'b0;
      mmu_cycle     <= 3'd0;
      tile_count    <= 8'd0;
      weight0       <= 8'd0;
      weight1       <= 8'd0;
      weight2       <= 8'd0;
      weight3       <= 8'd0;
      input0        <= 8'd0;
      input1        <= 8'd0;
      input2        <= 8'd0;
      input3        <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          load_ready <= 1'b1;
          en         <= 1'b0;
          mmu_cycle  <= 3'd0;
          if (accept) begin
            if (skip_w) begin
              input0   <= load_data;
              byte_idx <= 3'd5;
            end else begin
              case (byte_idx)
                3'd0: weight0 <= load_data;
                3'd1: weight1 <= load_data;
                3'd2: weight2 <= load_data;
                3'd3: weight3 <= load_data;
                3'd4: input0  <= load_data;
                3'd5: input1  <= load_data;
                3'd6: input2  <= load_data;
                default: input3 <= load_data;
              endcase
              byte_idx <= byte_idx + 3'd1;
            end
            if (byte_idx == 3'd7) begin
              byte_idx      <= 3'd0;
              weights_valid <= 1'b1;
              state         <= RUN;
              load_ready    <= 1'b0;
              en            <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mmu_cycle == LAST) begin
            state      <= FLUSH;
            en         <= 1'b0;
            mmu_cycle  <= 3'd0;
            gap        <= 4'd0;
            tile_count <= tile_count + 8'd1;
          end else begin
            mmu_cycle <= mmu_cycle + 3'd1;
          end
        end
        FLUSH: begin
          // Array clears while en is low; reopen only after the full gap.
          if (gap == GAP_END) begin
            state      <= LOAD;
            load_ready <= 1'b1;
          end else begin
            gap <= gap + 4'd1;
          end
        end
        default: begin
          state      <= LOAD;
          en         <= 1'b0;
          mmu_cycle  <= 3'd0;
          load_ready <= 1'b0;
          byte_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: loading, reuse, hold, reset, wrap,
// plus a second instance with a longer pass and gap.
module tb_mmu_sequencer;
  localparam int L = 5;
  localparam int G = 1;

  logic clk = 0;
  logic rst = 1;
  logic load_valid = 0;
  logic [7:0] load_data = 0;
  logic reuse = 0;
  logic load_ready, en, busy;
  logic [2:0] mmu_cycle;
  logic [7:0] w0, w1, w2, w3, i0, i1, i2, i3, tile_count;

  logic ready2, en2, busy2;
  logic [2:0] cyc2;
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3, tc2;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mmu_sequencer #(.LAST_CYCLE(L), .CLEAR_GAP(G)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .load_data(load_data), .reuse_weights(reuse),
    .load_ready(load_ready), .en(en), .mmu_cycle(mmu_cycle),
    .weight0(w0), .weight1(w1), .weight2(w2), .weight3(w3),
    .input0(i0), .input1(i1), .input2(i2), .input3(i3),
    .busy(busy), .tile_count(tile_count)
  );

  mmu_sequencer #(.LAST_CYCLE(7), .CLEAR_GAP(3)) dut2 (
    .clk(clk), .rst(rst), .load_valid(1'b1),
    .load_data(8'h11), .reuse_weights(1'b0),
    .load_ready(ready2), .en(en2), .mmu_cycle(cyc2),
    .weight0(a0), .weight1(a1), .weight2(a2), .weight3(a3),
    .input0(b0), .input1(b1), .input2(b2), .input3(b3),
    .busy(busy2), .tile_count(tc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input logic [7:0] w [4],
                          input logic [7:0] x [4]);
    chk("weight0", 32'(w0), 32'(w[0]));
    chk("weight1", 32'(w1), 32'(w[1]));
    chk("weight2", 32'(w2), 32'(w[2]));
    chk("weight3", 32'(w3), 32'(w[3]));
    chk("input0", 32'(i0), 32'(x[0]));
    chk("input1", 32'(i1), 32'(x[1]));
    chk("input2", 32'(i2), 32'(x[2]));
    chk("input3", 32'(i3), 32'(x[3]));
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input logic r);
    int t = 0;
    while (!load_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'(load_ready), 32'd1);
    load_valid = 1;
    load_data = b;
    reuse = r;
    @(negedge clk);
    load_valid = 0;
    reuse = 0;
  endtask

  task automatic check_pass(input logic [7:0] exp_tile,
                            input bit noise);
    for (int k = 0; k <= L; k++) begin
      chk("run_en", 32'(en), 32'd1);
      chk("run_cycle", 32'(mmu_cycle), 32'(k));
      chk("run_ready", 32'(load_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_tile", 32'(tile_count), 32'(8'(exp_tile - 8'd1)));
      if (noise) begin
        load_valid = k[0];
        load_data = 8'hAA;
        reuse = 1;
      end
      @(negedge clk);
    end
    for (int g = 0; g < G; g++) begin
      chk("flush_en", 32'(en), 32'd0);
      chk("flush_cycle", 32'(mmu_cycle), 32'd0);
      chk("flush_ready", 32'(load_ready), 32'd0);
      chk("flush_busy", 32'(busy), 32'd1);
      chk("flush_tile", 32'(tile_count), 32'(exp_tile));
      if (noise) begin
        load_valid = 1;
        load_data = 8'hAA;
      end
      @(negedge clk);
    end
    load_valid = 0;
    reuse = 0;
    chk("done_ready", 32'(load_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_en", 32'(en), 32'd0);
    chk("done_tile", 32'(tile_count), 32'(exp_tile));
  endtask

  initial begin
    logic [7:0] ew [4];
    logic [7:0] ex [4];
    int n, t;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_cycle", 32'(mmu_cycle), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tile", 32'(tile_count), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("ready_rise", 32'(load_ready), 32'd1);

    // Reuse flag right after reset is ignored; all 8 bytes load.
    for (int b = 1; b <= 8; b++) begin
      send(8'(b), 1'b1);
      if (b == 4) chk("no_run_after4", 32'(en), 32'd0);
    end
    check_pass(8'd1, 1'b0);
    ew = '{8'd1, 8'd2, 8'd3, 8'd4};
    ex = '{8'd5, 8'd6, 8'd7, 8'd8};
    chk_data(ew, ex);

    // Inputs-only tile, with noise on load_valid during the pass.
    send(8'd9, 1'b1);
    for (int b = 10; b <= 12; b++) send(8'(b), 1'b0);
    check_pass(8'd2, 1'b1);
    ex = '{8'd9, 8'd10, 8'd11, 8'd12};
    chk_data(ew, ex);

    // Noise had no effect: a reuse tile again takes exactly 4 bytes.
    send(8'd13, 1'b1);
    for (int b = 14; b <= 16; b++) send(8'(b), 1'b0);
    chk("reuse_en", 32'(en), 32'd1);
    ex = '{8'd13, 8'd14, 8'd15, 8'd16};
    chk_data(ew, ex);
    repeat (3) @(negedge clk);
    chk("pre_rst_cycle", 32'(mmu_cycle), 32'd3);
    rst = 1;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_cycle", 32'(mmu_cycle), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tile", 32'(tile_count), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd0);
    ew = '{8'd0, 8'd0, 8'd0, 8'd0};
    ex = '{8'd0, 8'd0, 8'd0, 8'd0};
    chk_data(ew, ex);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Weights were invalidated: reuse request still needs 8 bytes.
    send(8'd21, 1'b1);
    for (int b = 22; b <= 24; b++) send(8'(b), 1'b0);
    chk("post_rst_en", 32'(en), 32'd0);
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    for (int b = 25; b <= 28; b++) send(8'(b), 1'b0);
    check_pass(8'd1, 1'b0);
    ew = '{8'd21, 8'd22, 8'd23, 8'd24};
    ex = '{8'd25, 8'd26, 8'd27, 8'd28};
    chk_data(ew, ex);

    // Back-to-back reuse tiles until tile_count wraps.
    for (int k = 2; k <= 256; k++) begin
      send(8'(k), 1'b1);
      for (int b = 1; b <= 3; b++) send(8'(k + b), 1'b0);
      check_pass(8'(k), 1'b0);
    end
    chk("wrap_tile", 32'(tile_count), 32'd0);

    // Second instance: LAST_CYCLE=7, CLEAR_GAP=3.
    t = 0;
    while (en2 && t < 100) begin @(negedge clk); t++; end
    while (!en2 && t < 100) begin @(negedge clk); t++; end
    chk("en2_found", 32'(t < 100), 32'd1);
    n = 0;
    while (en2 && n < 20) begin
      chk("cyc2", 32'(cyc2), 32'(n));
      n++;
      @(negedge clk);
    end
    chk("en2_high", 32'(n), 32'd8);
    n = 0;
    while (!ready2 && n < 20) begin
      chk("gap2_en", 32'(en2), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("en2_gap", 32'(n), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
